// File: rtl/cc_bus_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : cc_bus_reg_file_pkg
// Brief  : Shared types for the MCU bus register file (FSM states, strobes).
// Rev    : 1.0  initial release
// ============================================================================
package cc_bus_reg_file_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        CC_BUS_IDLE  = 2'd0,
        CC_BUS_READ  = 2'd1,
        CC_BUS_WRITE = 2'd2
    } cc_bus_state_t;

    typedef struct packed {
        logic cs_n;
        logic rd_n;
        logic wr_n;
    } cc_strobes_t;

    localparam cc_strobes_t c_STROBES_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1};

    function automatic logic strobe_is_read(input cc_strobes_t s);
        return !s.cs_n && !s.rd_n && s.wr_n;
    endfunction

    function automatic logic strobe_is_write(input cc_strobes_t s);
        return !s.cs_n && !s.wr_n && s.rd_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_sync_stage.sv
`default_nettype none
// ============================================================================
// Module : cc_sync_stage
// Brief  : DEPTH-flop synchroniser/delay line with async active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
module cc_sync_stage #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VALUE;
        end else begin
            r_pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign q = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cc_bus_reg_file.sv
`default_nettype none
// ============================================================================
// Module : cc_bus_reg_file
// Brief  : Register file on an async MCU parallel bus plus a fabric load port.
// Rev    : 1.0  initial release
// ============================================================================
module cc_bus_reg_file
    import cc_bus_reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = (1 << ADDR_WIDTH),
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           bus_cs_n,
    input  logic                           bus_rd_n,
    input  logic                           bus_wr_n,
    input  logic [ADDR_WIDTH-1:0]          bus_addr,
    inout  wire  [DATA_WIDTH-1:0]          bus_data,
    input  logic                           hw_load,
    input  logic [ADDR_WIDTH-1:0]          hw_load_addr,
    input  logic [DATA_WIDTH-1:0]          hw_load_data,
    output logic                           hw_load_ack,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_values,
    output logic [NUM_REGS-1:0]            reg_written
);

    cc_strobes_t                 w_strobe_raw;
    cc_strobes_t                 w_strobe;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic [DATA_WIDTH-1:0]       w_data;

    cc_bus_state_t               r_state;
    cc_bus_state_t               w_state_next;
    logic                        w_commit_req;
    logic                        w_commit;
    logic                        w_hw_accept;
    logic [DATA_WIDTH-1:0]       w_rd_value;

    logic [DATA_WIDTH-1:0]       r_regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0]       r_wr_addr;
    logic [DATA_WIDTH-1:0]       r_wr_data;
    logic [DATA_WIDTH-1:0]       r_rd_buf;
    logic                        r_oe;
    logic                        r_ack;
    logic [NUM_REGS-1:0]         r_written;

    assign w_strobe_raw = '{cs_n: bus_cs_n, rd_n: bus_rd_n, wr_n: bus_wr_n};

    // Address and data go through the same depth so they stay aligned with the strobes.
    cc_sync_stage #(
        .WIDTH       (3),
        .DEPTH       (SYNC_STAGES),
        .RESET_VALUE (c_STROBES_IDLE)
    ) u_sync_strobe (
        .clk   (clk),
        .reset (reset),
        .d     (w_strobe_raw),
        .q     (w_strobe)
    );

    cc_sync_stage #(
        .WIDTH       (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH       (SYNC_STAGES),
        .RESET_VALUE ('0)
    ) u_sync_addr_data (
        .clk   (clk),
        .reset (reset),
        .d     ({bus_addr, bus_data}),
        .q     ({w_addr, w_data})
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= CC_BUS_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_commit_req = 1'b0;
        unique case (r_state)
            CC_BUS_IDLE: begin
                if (strobe_is_read(w_strobe))       w_state_next = CC_BUS_READ;
                else if (strobe_is_write(w_strobe)) w_state_next = CC_BUS_WRITE;
            end
            CC_BUS_READ: begin
                if (w_strobe.cs_n || w_strobe.rd_n) w_state_next = CC_BUS_IDLE;
            end
            CC_BUS_WRITE: begin
                if (w_strobe.cs_n || w_strobe.wr_n) begin
                    w_state_next = CC_BUS_IDLE;
                    w_commit_req = 1'b1;
                end
            end
            default: w_state_next = CC_BUS_IDLE;
        endcase
    end

    // A bus commit to an unimplemented address is no commit at all.
    assign w_commit    = w_commit_req && (32'(r_wr_addr) < 32'(NUM_REGS));
    assign w_hw_accept = hw_load && (32'(hw_load_addr) < 32'(NUM_REGS)) && !w_commit;

    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr == ADDR_WIDTH'(i)) w_rd_value = r_regs[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_written <= '0;
            r_ack     <= 1'b0;
        end else begin
            r_written <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (r_wr_addr == ADDR_WIDTH'(i))) begin
                    r_regs[i]    <= r_wr_data;
                    r_written[i] <= 1'b1;
                end else if (w_hw_accept && (hw_load_addr == ADDR_WIDTH'(i))) begin
                    r_regs[i] <= hw_load_data;
                end
            end
            r_ack <= w_hw_accept;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_buf  <= '0;
            r_oe      <= 1'b0;
        end else begin
            if (w_state_next == CC_BUS_WRITE) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
            // Snapshot only on entry so a mid-read register update is not visible.
            if ((r_state == CC_BUS_IDLE) && (w_state_next == CC_BUS_READ)) begin
                r_rd_buf <= w_rd_value;
            end
            r_oe <= (w_state_next == CC_BUS_READ);
        end
    end

    assign bus_data = r_oe ? r_rd_buf : {DATA_WIDTH{1'bz}};

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign reg_values[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    assign reg_written = r_written;
    assign hw_load_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_cc_bus_reg_file.sv
`default_nettype none
// ============================================================================
// Module : tb_cc_bus_reg_file
// Brief  : Self-checking bench for cc_bus_reg_file (NUM_REGS=10 instance).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cc_bus_reg_file;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NR = 10;
    localparam int SS = 2;
    localparam int VW = NR * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            cs_n, rd_n, wr_n;
    logic [AW-1:0]   addr;
    logic            drv_en;
    logic [DW-1:0]   drv_data;
    wire  [DW-1:0]   bus_data;
    logic            hw_load;
    logic [AW-1:0]   hw_addr;
    logic [DW-1:0]   hw_data;
    logic            hw_ack;
    logic [VW-1:0]   reg_values;
    logic [NR-1:0]   reg_written;

    always #5 clk = ~clk;

    assign bus_data = drv_en ? drv_data : {DW{1'bz}};

    cc_bus_reg_file #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_cs_n    (cs_n),
        .bus_rd_n    (rd_n),
        .bus_wr_n    (wr_n),
        .bus_addr    (addr),
        .bus_data    (bus_data),
        .hw_load     (hw_load),
        .hw_load_addr(hw_addr),
        .hw_load_data(hw_data),
        .hw_load_ack (hw_ack),
        .reg_values  (reg_values),
        .reg_written (reg_written)
    );

    logic [DW-1:0] model [NR];
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit            is_write;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } vec_t;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NR;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (in_range(a)) return model[a];
        return '0;
    endfunction

    function automatic logic [VW-1:0] model_flat();
        logic [VW-1:0] v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
        repeat (SS + 2) tick();
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int hold, input string name);
        logic [NR-1:0] seen = '0;
        int pulses = 0;
        int at     = -1;
        addr = a; drv_data = d; drv_en = 1'b1; cs_n = 1'b0;
        tick();
        wr_n = 1'b0;
        repeat (hold) tick();
        wr_n = 1'b1;
        for (int c = 1; c <= SS + 3; c++) begin
            tick();
            if (reg_written != '0) begin
                pulses++;
                seen = seen | reg_written;
                if (at < 0) at = c;
            end
        end
        if (in_range(a)) model[a] = d;
        check({name, " pulse"}, VW'(seen), in_range(a) ? (VW'(1) << a) : '0);
        check({name, " pulse count"}, VW'(pulses), VW'(in_range(a)));
        if (in_range(a)) check({name, " pulse timing"}, VW'(at), VW'(SS + 1));
        check({name, " regs"}, reg_values, model_flat());
        idle_gap();
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                            input bit mid_load, input string name);
        bit released = 1'b0;
        addr = a; drv_en = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        for (int c = 1; c <= SS + 2; c++) begin
            tick();
            if (bus_data === exp) break;
        end
        check({name, " data"}, VW'(bus_data), VW'(exp));
        if (mid_load) begin
            hw_load = 1'b1; hw_addr = a; hw_data = ~exp;
            tick();
            hw_load = 1'b0;
            check({name, " midload ack"}, VW'(hw_ack), VW'(in_range(a)));
            if (in_range(a)) model[a] = ~exp;
        end
        tick();
        check({name, " hold"}, VW'(bus_data), VW'(exp));
        rd_n = 1'b1; cs_n = 1'b1;
        for (int c = 1; c <= SS + 1; c++) begin
            tick();
            if (bus_data !== exp) begin
                released = 1'b1;
                break;
            end
        end
        if (exp != '0) check({name, " release"}, VW'(released), VW'(1));
        idle_gap();
    endtask

    task automatic hw_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
        hw_load = 1'b1; hw_addr = a; hw_data = d;
        tick();
        hw_load = 1'b0;
        check({name, " ack"}, VW'(hw_ack), VW'(in_range(a)));
        if (in_range(a)) model[a] = d;
        tick();
        check({name, " ack drop"}, VW'(hw_ack), '0);
        check({name, " no pulse"}, VW'(reg_written), '0);
        check({name, " regs"}, reg_values, model_flat());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        logic [NR-1:0] acc;

        tbl[0]  = '{1'b1, 4'd0,  8'h11};
        tbl[1]  = '{1'b1, 4'd9,  8'h99};
        tbl[2]  = '{1'b1, 4'd4,  8'hC3};
        tbl[3]  = '{1'b1, 4'd12, 8'hEE};
        tbl[4]  = '{1'b0, 4'd0,  8'h11};
        tbl[5]  = '{1'b0, 4'd9,  8'h99};
        tbl[6]  = '{1'b0, 4'd4,  8'hC3};
        tbl[7]  = '{1'b0, 4'd12, 8'h00};
        tbl[8]  = '{1'b1, 4'd4,  8'h3C};
        tbl[9]  = '{1'b0, 4'd4,  8'h3C};
        tbl[10] = '{1'b0, 4'd1,  8'h00};

        reset = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; drv_en = 1'b0; drv_data = '0;
        hw_load = 1'b0; hw_addr = '0; hw_data = '0;
        model_clear();
        repeat (3) tick();
        check("reset regs", reg_values, '0);
        check("reset written", VW'(reg_written), '0);
        check("reset ack", VW'(hw_ack), '0);
        reset = 1'b1;
        idle_gap();

        foreach (tbl[i]) begin
            if (tbl[i].is_write) bus_write(tbl[i].a, tbl[i].d, 2, $sformatf("tbl%0d wr", i));
            else                 bus_read(tbl[i].a, tbl[i].d, 1'b0, $sformatf("tbl%0d rd", i));
        end

        bus_write(4'd3, 8'hA5, 6, "wr3");
        bus_read(4'd3, 8'hA5, 1'b1, "rd3 midload");
        check("rd3 after midload", VW'(reg_values[3*DW +: DW]), VW'(8'h5A));

        // Fabric load landing on the same clk as a bus commit.
        addr = 4'd2; drv_data = 8'h6E; drv_en = 1'b1; cs_n = 1'b0;
        tick();
        wr_n = 1'b0;
        repeat (3) tick();
        wr_n = 1'b1;
        repeat (SS) tick();
        hw_load = 1'b1; hw_addr = 4'd7; hw_data = 8'h3C;
        tick();
        hw_load = 1'b0;
        model[2] = 8'h6E;
        check("collide ack", VW'(hw_ack), '0);
        check("collide pulse", VW'(reg_written), VW'(10'h004));
        check("collide regs", reg_values, model_flat());
        hw_write(4'd7, 8'h3C, "retry");
        idle_gap();

        hw_write(4'd11, 8'h77, "hw oor");

        // rd_n and wr_n low together.
        addr = 4'd3; drv_en = 1'b0; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        acc = '0;
        for (int c = 0; c < SS + 4; c++) begin
            tick();
            acc = acc | reg_written;
        end
        check("illegal drive", VW'(bus_data !== 8'h5A), VW'(1));
        check("illegal pulse", VW'(acc), '0);
        idle_gap();
        check("illegal regs", reg_values, model_flat());

        // Reset during a read: bus must release without waiting for a clock.
        addr = 4'd3; cs_n = 1'b0; rd_n = 1'b0;
        repeat (SS + 2) tick();
        check("pre-reset drive", VW'(bus_data), VW'(8'h5A));
        reset = 1'b0;
        #1;
        check("reset release", VW'(bus_data !== 8'h5A), VW'(1));
        check("reset mid-read regs", reg_values, '0);
        cs_n = 1'b1; rd_n = 1'b1;
        tick();
        reset = 1'b1;
        model_clear();
        idle_gap();

        // Reset during a write: pending write is discarded.
        addr = 4'd5; drv_data = 8'h77; drv_en = 1'b1; cs_n = 1'b0;
        tick();
        wr_n = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        cs_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
        tick();
        reset = 1'b1;
        acc = '0;
        for (int c = 0; c < SS + 4; c++) begin
            tick();
            acc = acc | reg_written;
        end
        check("reset mid-write pulse", VW'(acc), '0);
        check("reset mid-write regs", reg_values, '0);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;
            int op;
            op = $urandom_range(0, 2);
            ra = AW'($urandom_range(0, 15));
            rd = DW'($urandom);
            case (op)
                0: bus_write(ra, rd, $urandom_range(1, 4), $sformatf("rnd%0d wr", n));
                1: bus_read(ra, model_rd(ra), 1'b0, $sformatf("rnd%0d rd", n));
                default: hw_write(ra, rd, $sformatf("rnd%0d hw", n));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
